// File: rtl/tick_run_controller.sv
// Run/pause/stop sequencer for the tick divider: turns button presses into divider
// controls and counts ticks to TARGET. Optional build macro: AUTO_RELOAD_EN.
module tick_run_controller #(
    parameter int CNT_WIDTH = 4,
    parameter int TARGET    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_btn,
    input  logic                 pause_btn,
    input  logic                 stop_btn,
    input  logic                 tick_in,
    output logic                 div_en,
    output logic                 div_clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 running,
    output logic                 paused,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ZERO_C      = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE_C       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] TARGET_C    = CNT_WIDTH'(TARGET);
    localparam logic [CNT_WIDTH-1:0] TARGET_M1_C = CNT_WIDTH'(TARGET - 1);

    state_t               state_r;
    state_t               state_next_s;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_next_s;
    logic                 done_r;
    logic                 done_next_s;
    logic                 div_en_r;
    logic                 div_clr_r;
    logic                 running_r;
    logic                 paused_r;
    logic                 div_en_next_s;
    logic                 div_clr_next_s;
    logic                 running_next_s;
    logic                 paused_next_s;

    // Previous button levels; reset high so a button held through reset is not an event.
    logic start_q_r;
    logic pause_q_r;
    logic stop_q_r;
    logic start_ev_s;
    logic pause_ev_s;
    logic stop_ev_s;
    logic terminal_s;

    assign start_ev_s = start_btn & ~start_q_r;
    assign pause_ev_s = pause_btn & ~pause_q_r;
    assign stop_ev_s  = stop_btn & ~stop_q_r;
    assign terminal_s = tick_in & (count_r == TARGET_M1_C);

    // Next-state and next-count logic; stop beats every other event and any tick.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        done_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (stop_ev_s) begin
                    state_next_s = ST_IDLE;
                    count_next_s = ZERO_C;
                end else if (start_ev_s) begin
                    state_next_s = ST_RUN;
                    count_next_s = ZERO_C;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_ev_s) begin
                    state_next_s = ST_IDLE;
                    count_next_s = ZERO_C;
                end else if (tick_in) begin
                    if (terminal_s) begin
                        done_next_s = 1'b1;
`ifdef AUTO_RELOAD_EN
                        count_next_s = ZERO_C;
                        state_next_s = pause_ev_s ? ST_PAUSE : ST_RUN;
`else
                        count_next_s = TARGET_C;
                        state_next_s = ST_DONE;
`endif
                    end else begin
                        count_next_s = count_r + ONE_C;
                        state_next_s = pause_ev_s ? ST_PAUSE : ST_RUN;
                    end
                end else if (pause_ev_s) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (stop_ev_s) begin
                    state_next_s = ST_IDLE;
                    count_next_s = ZERO_C;
                end else if (start_ev_s || pause_ev_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (stop_ev_s) begin
                    state_next_s = ST_IDLE;
                    count_next_s = ZERO_C;
                end else if (start_ev_s) begin
                    state_next_s = ST_RUN;
                    count_next_s = ZERO_C;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                count_next_s = ZERO_C;
            end
        endcase
    end

    // Divider controls and status decoded from the upcoming state so they register with it.
    always_comb begin
        div_en_next_s  = 1'b0;
        div_clr_next_s = 1'b1;
        running_next_s = 1'b0;
        paused_next_s  = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                div_en_next_s  = 1'b0;
                div_clr_next_s = 1'b1;
            end
            ST_RUN: begin
                div_en_next_s  = 1'b1;
                div_clr_next_s = 1'b0;
                running_next_s = 1'b1;
            end
            ST_PAUSE: begin
                div_en_next_s  = 1'b0;
                div_clr_next_s = 1'b0;
                paused_next_s  = 1'b1;
            end
            ST_DONE: begin
                div_en_next_s  = 1'b0;
                div_clr_next_s = 1'b1;
            end
            default: begin
                div_en_next_s  = 1'b0;
                div_clr_next_s = 1'b1;
            end
        endcase
    end

    // State, count, button history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            count_r   <= ZERO_C;
            done_r    <= 1'b0;
            div_en_r  <= 1'b0;
            div_clr_r <= 1'b1;
            running_r <= 1'b0;
            paused_r  <= 1'b0;
            start_q_r <= 1'b1;
            pause_q_r <= 1'b1;
            stop_q_r  <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            count_r   <= count_next_s;
            done_r    <= done_next_s;
            div_en_r  <= div_en_next_s;
            div_clr_r <= div_clr_next_s;
            running_r <= running_next_s;
            paused_r  <= paused_next_s;
            start_q_r <= start_btn;
            pause_q_r <= pause_btn;
            stop_q_r  <= stop_btn;
        end
    end

    assign div_en  = div_en_r;
    assign div_clr = div_clr_r;
    assign count   = count_r;
    assign running = running_r;
    assign paused  = paused_r;
    assign done    = done_r;

endmodule

// File: tb/tb_tick_run_controller.sv
// Directed bench for tick_run_controller with TARGET=3; expectations queued per step.
// Build with AUTO_RELOAD_EN defined to exercise the auto-reload variant.
module tb_tick_run_controller;

    logic       clk;
    logic       rst;
    logic       start_btn;
    logic       pause_btn;
    logic       stop_btn;
    logic       tick_in;
    logic       div_en;
    logic       div_clr;
    logic [3:0] count;
    logic       running;
    logic       paused;
    logic       done;

    int n_cmp;
    int n_err;
    logic [8:0] exp_q[$];

    tick_run_controller #(.CNT_WIDTH(4), .TARGET(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_btn(start_btn),
        .pause_btn(pause_btn),
        .stop_btn (stop_btn),
        .tick_in  (tick_in),
        .div_en   (div_en),
        .div_clr  (div_clr),
        .count    (count),
        .running  (running),
        .paused   (paused),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {count, running, paused, div_en, div_clr, done}
    function automatic logic [8:0] ex(input logic [3:0] c, input logic r, input logic p,
                                      input logic en, input logic cl, input logic d);
        return {c, r, p, en, cl, d};
    endfunction
    function automatic logic [8:0] e_idle();
        return ex(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic logic [8:0] e_run(input logic [3:0] c, input logic d);
        return ex(c, 1'b1, 1'b0, 1'b1, 1'b0, d);
    endfunction
    function automatic logic [8:0] e_pause(input logic [3:0] c);
        return ex(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [8:0] e_done(input logic d);
        return ex(4'd3, 1'b0, 1'b0, 1'b0, 1'b1, d);
    endfunction

    task automatic compare(input string tag);
        logic [8:0] obs;
        logic [8:0] expv;
        obs  = {count, running, paused, div_en, div_clr, done};
        expv = exp_q.pop_front();
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
    task automatic cyc(input string tag, input logic s, input logic p, input logic st,
                       input logic t, input logic [8:0] e);
        start_btn = s;
        pause_btn = p;
        stop_btn  = st;
        tick_in   = t;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic chk_now(input string tag, input logic [8:0] e);
        exp_q.push_back(e);
        compare(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        stop_btn  = 1'b0;
        tick_in   = 1'b0;
        #12;
        chk_now("reset", e_idle());
        @(negedge clk);
        rst = 1'b0;
        cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, e_idle());
        cyc("idle_pause_tick", 1'b0, 1'b1, 1'b0, 1'b1, e_idle());
        cyc("start", 1'b1, 1'b0, 1'b0, 1'b0, e_run(4'd0, 1'b0));
        cyc("run_hold", 1'b0, 1'b0, 1'b0, 1'b0, e_run(4'd0, 1'b0));
`ifndef AUTO_RELOAD_EN
        // Count to terminal
        cyc("tick1", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd1, 1'b0));
        cyc("tick2", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd2, 1'b0));
        cyc("tick3_done", 1'b0, 1'b0, 1'b0, 1'b1, e_done(1'b1));
        cyc("done_drop", 1'b0, 1'b0, 1'b0, 1'b1, e_done(1'b0));
        // Pause holds count, resume continues
        cyc("restart", 1'b1, 1'b0, 1'b0, 1'b0, e_run(4'd0, 1'b0));
        cyc("p_tick1", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd1, 1'b0));
        cyc("p_tick2", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd2, 1'b0));
        cyc("pause", 1'b0, 1'b1, 1'b0, 1'b0, e_pause(4'd2));
        for (int i = 0; i < 5; i++) begin
            cyc("paused_tick", 1'b0, 1'b0, 1'b0, 1'b1, e_pause(4'd2));
        end
        cyc("resume", 1'b0, 1'b1, 1'b0, 1'b0, e_run(4'd2, 1'b0));
        cyc("resume_tick", 1'b0, 1'b0, 1'b0, 1'b1, e_done(1'b1));
        cyc("stop_done", 1'b0, 1'b0, 1'b1, 1'b0, e_idle());
        // Stop with tick discards the tick; pause with tick counts it first
        cyc("start3", 1'b1, 1'b0, 1'b0, 1'b0, e_run(4'd0, 1'b0));
        cyc("t3_tick", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd1, 1'b0));
        cyc("stop_tick", 1'b0, 1'b0, 1'b1, 1'b1, e_idle());
        cyc("start3b", 1'b1, 1'b0, 1'b0, 1'b0, e_run(4'd0, 1'b0));
        cyc("t3b_tick", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd1, 1'b0));
        cyc("pause_tick", 1'b0, 1'b1, 1'b0, 1'b1, e_pause(4'd2));
        cyc("pause_held", 1'b0, 1'b1, 1'b0, 1'b1, e_pause(4'd2));
        cyc("start_resume", 1'b1, 1'b0, 1'b0, 1'b0, e_run(4'd2, 1'b0));
        cyc("start_in_run", 1'b0, 1'b0, 1'b0, 1'b0, e_run(4'd2, 1'b0));
        cyc("pause_term_tick", 1'b0, 1'b1, 1'b0, 1'b1, e_done(1'b1));
        cyc("done_hold", 1'b0, 1'b0, 1'b0, 1'b0, e_done(1'b0));
        cyc("done_pause_ign", 1'b0, 1'b1, 1'b0, 1'b0, e_done(1'b0));
        cyc("stop_prio", 1'b1, 1'b0, 1'b1, 1'b0, e_idle());
`else
        // Auto-reload: wraps to 0 at terminal and stays running
        cyc("ar_t1", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd1, 1'b0));
        cyc("ar_t2", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd2, 1'b0));
        cyc("ar_t3", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd0, 1'b1));
        cyc("ar_t4", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd1, 1'b0));
        cyc("ar_t5", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd2, 1'b0));
        cyc("ar_t6", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd0, 1'b1));
        cyc("ar_t7", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd1, 1'b0));
        cyc("ar_idle", 1'b0, 1'b0, 1'b0, 1'b0, e_run(4'd1, 1'b0));
        cyc("ar_pause", 1'b0, 1'b1, 1'b0, 1'b1, e_pause(4'd2));
        cyc("ar_stop", 1'b0, 1'b0, 1'b1, 1'b0, e_idle());
`endif
        // Button held through reset release is ignored until released
        @(negedge clk);
        rst = 1'b1;
        start_btn = 1'b1;
        @(negedge clk);
        chk_now("hold_reset", e_idle());
        rst = 1'b0;
        cyc("hold1", 1'b1, 1'b0, 1'b0, 1'b0, e_idle());
        cyc("hold2", 1'b1, 1'b0, 1'b0, 1'b0, e_idle());
        cyc("release", 1'b0, 1'b0, 1'b0, 1'b0, e_idle());
        cyc("press", 1'b1, 1'b0, 1'b0, 1'b0, e_run(4'd0, 1'b0));
        // Asynchronous reset in the middle of a run
        cyc("m_tick1", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd1, 1'b0));
        cyc("m_tick2", 1'b0, 1'b0, 1'b0, 1'b1, e_run(4'd2, 1'b0));
        tick_in = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_now("async_reset", e_idle());
        @(negedge clk);
        rst = 1'b0;
        cyc("post_reset", 1'b0, 1'b0, 1'b0, 1'b1, e_idle());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
